// File: rtl/output_fader.sv
// output_fader -- final gain/fade stage ahead of the I2S transmitter.
//
// Once per audio frame (rising edge of the synchronised DAC LR clock) the
// left/right samples are scaled by a shared unsigned gain and saturated.
// The applied gain ramps toward the requested target by RAMP_STEP per frame,
// so volume changes and mute never produce a step in the output.
//
// Ports:
//   clk          system clock
//   rst          synchronous active-high reset (aborts any frame in flight)
//   lrclk        DAC LR clock, asynchronous to clk; rising edge = new frame
//   in_l, in_r   signed input samples, sampled once per frame
//   target_gain  requested gain, unsigned, 1<<(GAINBITS-1) = unity
//   mute         forces the effective target to 0
//   out_l, out_r scaled, saturated output samples (registered)
//   sample_valid one-clk pulse when out_l/out_r update
//   cur_gain     gain currently applied
//
// Optional build macro OUTPUT_FADER_CLIP_DETECT_EN adds:
//   clip_clear   input, clears both clip flags (wins over a same-cycle set)
//   clip_l/clip_r sticky flags, set when that channel saturated
module output_fader #(
  parameter int                    BITSIZE   = 16,
  parameter int                    GAINBITS  = 16,
  parameter logic [GAINBITS-1:0]   RAMP_STEP = 16'h0100
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                lrclk,
  input  logic [BITSIZE-1:0]  in_l,
  input  logic [BITSIZE-1:0]  in_r,
  input  logic [GAINBITS-1:0] target_gain,
  input  logic                mute,
  output logic [BITSIZE-1:0]  out_l,
  output logic [BITSIZE-1:0]  out_r,
  output logic                sample_valid,
  output logic [GAINBITS-1:0] cur_gain
`ifdef OUTPUT_FADER_CLIP_DETECT_EN
  ,
  input  logic                clip_clear,
  output logic                clip_l,
  output logic                clip_r
`endif
);

  localparam int PW = BITSIZE + GAINBITS + 1;
  localparam logic signed [PW-1:0] SAT_MAX = {{(PW-BITSIZE+1){1'b0}}, {(BITSIZE-1){1'b1}}};
  localparam logic signed [PW-1:0] SAT_MIN = {{(PW-BITSIZE+1){1'b1}}, {(BITSIZE-1){1'b0}}};

  typedef enum logic [2:0] {IDLE, CAPTURE, MUL_L, MUL_R, OUT} state_t;

  state_t state;
  logic   lr_s1, lr_s2, lr_s3;
  logic   frame_edge;

  logic signed [BITSIZE-1:0] in_l_p0, in_r_p0;
  logic        [GAINBITS-1:0] tgt_p0;
  logic signed [PW-1:0]       prod_l_p1, prod_r_p2;
  logic signed [BITSIZE-1:0]  mul_a;
  logic signed [GAINBITS:0]   mul_g;
  logic signed [PW-1:0]       prod_c;

  // Drop the gain fraction bits; arithmetic shift truncates toward -inf.
  function automatic logic signed [PW-1:0] scale_shift(input logic signed [PW-1:0] p);
    return p >>> (GAINBITS-1);
  endfunction

  function automatic logic signed [BITSIZE-1:0] saturate(input logic signed [PW-1:0] p);
    logic signed [PW-1:0] s;
    s = scale_shift(p);
    if (s > SAT_MAX)      return SAT_MAX[BITSIZE-1:0];
    else if (s < SAT_MIN) return SAT_MIN[BITSIZE-1:0];
    else                  return s[BITSIZE-1:0];
  endfunction

`ifdef OUTPUT_FADER_CLIP_DETECT_EN
  function automatic logic sat_hit(input logic signed [PW-1:0] p);
    logic signed [PW-1:0] s;
    s = scale_shift(p);
    return (s > SAT_MAX) || (s < SAT_MIN);
  endfunction
`endif

  // One ramp step toward tgt, clamped at tgt; one extra bit so it cannot wrap.
  function automatic logic [GAINBITS-1:0] ramp(input logic [GAINBITS-1:0] cur,
                                               input logic [GAINBITS-1:0] tgt);
    logic [GAINBITS:0] up, dn;
    up = {1'b0, cur} + {1'b0, RAMP_STEP};
    dn = {1'b0, cur} - {1'b0, RAMP_STEP};
    if (cur < tgt)
      return (up > {1'b0, tgt}) ? tgt : up[GAINBITS-1:0];
    else if (cur > tgt)
      return ((cur < RAMP_STEP) || (dn < {1'b0, tgt})) ? tgt : dn[GAINBITS-1:0];
    else
      return cur;
  endfunction

  assign frame_edge = lr_s2 & ~lr_s3;

  // Single multiplier shared between the two channel states.
  assign mul_a  = (state == MUL_L) ? in_l_p0 : in_r_p0;
  assign mul_g  = $signed({1'b0, cur_gain});
  assign prod_c = PW'(mul_a) * PW'(mul_g);

  // ---- stage p0: capture samples and target; p1/p2: channel products ----
  always_ff @(posedge clk) begin
    if (state == CAPTURE) begin
      in_l_p0 <= $signed(in_l);
      in_r_p0 <= $signed(in_r);
      tgt_p0  <= mute ? '0 : target_gain;
    end
    if (state == MUL_L) prod_l_p1 <= prod_c;
    if (state == MUL_R) prod_r_p2 <= prod_c;
  end

  // ---- control: synchroniser, FSM, output stage ----
  always_ff @(posedge clk) begin
    if (rst) begin
      lr_s1        <= 1'b0;
      lr_s2        <= 1'b0;
      lr_s3        <= 1'b0;
      state        <= IDLE;
      out_l        <= '0;
      out_r        <= '0;
      sample_valid <= 1'b0;
      cur_gain     <= '0;
`ifdef OUTPUT_FADER_CLIP_DETECT_EN
      clip_l       <= 1'b0;
      clip_r       <= 1'b0;
`endif
    end else begin
      lr_s1        <= lrclk;
      lr_s2        <= lr_s1;
      lr_s3        <= lr_s2;
      sample_valid <= 1'b0;
`ifdef OUTPUT_FADER_CLIP_DETECT_EN
      if (clip_clear) begin
        clip_l <= 1'b0;
        clip_r <= 1'b0;
      end else if (state == OUT) begin
        clip_l <= clip_l | sat_hit(prod_l_p1);
        clip_r <= clip_r | sat_hit(prod_r_p2);
      end
`endif
      case (state)
        IDLE:    if (frame_edge) state <= CAPTURE;
        CAPTURE: state <= MUL_L;
        MUL_L:   state <= MUL_R;
        MUL_R:   state <= OUT;
        OUT: begin
          out_l        <= saturate(prod_l_p1);
          out_r        <= saturate(prod_r_p2);
          sample_valid <= 1'b1;
          cur_gain     <= ramp(cur_gain, tgt_p0);
          state        <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_output_fader.sv
module tb_output_fader;
  localparam int STEP = 'h1000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        lrclk = 1'b0;
  logic [15:0] in_l = '0, in_r = '0, target_gain = '0;
  logic        mute = 1'b0;
  logic [15:0] out_l, out_r, cur_gain;
  logic        sample_valid;
`ifdef OUTPUT_FADER_CLIP_DETECT_EN
  logic        clip_clear = 1'b0;
  logic        clip_l, clip_r;
`endif

  output_fader #(.BITSIZE(16), .GAINBITS(16), .RAMP_STEP(16'h1000)) dut (
    .clk(clk), .rst(rst), .lrclk(lrclk), .in_l(in_l), .in_r(in_r),
    .target_gain(target_gain), .mute(mute), .out_l(out_l), .out_r(out_r),
    .sample_valid(sample_valid), .cur_gain(cur_gain)
`ifdef OUTPUT_FADER_CLIP_DETECT_EN
    , .clip_clear(clip_clear), .clip_l(clip_l), .clip_r(clip_r)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Behavioural model: gain in plain integers, outputs from floor(x*g/2^15) clamped.
  typedef struct { int due; logic [15:0] l; logic [15:0] r; logic [15:0] g; } exp_t;
  exp_t q[$];
  int   m_gain = 0;
  logic [15:0] last_l, last_r, last_g;

  function automatic logic [15:0] m_scale(input int x, input int g);
    longint p;
    p = longint'(x) * longint'(g);
    p = p >>> 15;
    if (p > 32767)  p = 32767;
    if (p < -32768) p = -32768;
    return 16'(p);
  endfunction

  function automatic int m_ramp(input int cur, input int tgt);
    if (cur < tgt) return (cur + STEP > tgt) ? tgt : cur + STEP;
    if (cur > tgt) return (cur - STEP < tgt) ? tgt : cur - STEP;
    return cur;
  endfunction

  // Compare process: sample_valid every cycle, data whenever a frame is due.
  always @(negedge clk) begin
    bit ev;
    if (q.size() > 0 && q[0].due < cyc) begin
      tests++; fails++;
      $display("FAIL frame_missing: due cycle %0d, now %0d", q[0].due, cyc);
      void'(q.pop_front());
    end
    ev = (q.size() > 0) && (q[0].due == cyc);
    chk("sample_valid", {31'b0, sample_valid}, {31'b0, ev});
    if (ev) begin
      if (sample_valid) begin
        chk("out_l", {16'b0, out_l}, {16'b0, q[0].l});
        chk("out_r", {16'b0, out_r}, {16'b0, q[0].r});
        chk("cur_gain", {16'b0, cur_gain}, {16'b0, q[0].g});
        last_l = out_l; last_r = out_r; last_g = cur_gain;
      end
      void'(q.pop_front());
    end
  end

  // lrclk rise at a negedge; outputs due 7 posedges later.
  task automatic frame(input int l, input int r, input int tgt, input bit mt, input int hold);
    exp_t e;
    int   eff;
    @(negedge clk);
    in_l = 16'(l); in_r = 16'(r); target_gain = 16'(tgt); mute = mt;
    eff  = mt ? 0 : tgt;
    e.due = cyc + 7;
    e.l = m_scale(l, m_gain);
    e.r = m_scale(r, m_gain);
    m_gain = m_ramp(m_gain, eff);
    e.g = 16'(m_gain);
    q.push_back(e);
    lrclk = 1'b1;
    repeat (hold) @(negedge clk);
    lrclk = 1'b0;
    repeat (10) @(negedge clk);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_out_l", {16'b0, out_l}, 32'h0);
    chk("rst_out_r", {16'b0, out_r}, 32'h0);
    chk("rst_cur_gain", {16'b0, cur_gain}, 32'h0);
`ifdef OUTPUT_FADER_CLIP_DETECT_EN
    chk("rst_clip_l", {31'b0, clip_l}, 32'h0);
`endif
    rst = 1'b0;
    repeat (4) @(negedge clk);

    // Fade in from reset.
    for (int i = 0; i < 9; i++) begin
      frame('h4000, 'h4000, 'h8000, 1'b0, 12);
      if (i == 0) begin
        chk("fadein_f1_out", {16'b0, last_l}, 32'h0000);
        chk("fadein_f1_gain", {16'b0, last_g}, 32'h1000);
      end
      if (i == 1) chk("fadein_f2_out", {16'b0, last_l}, 32'h0800);
    end
    chk("fadein_f9_out", {16'b0, last_l}, 32'h4000);
    chk("fadein_f9_gain", {16'b0, last_g}, 32'h8000);

    // Unity gain passes a small negative value unchanged.
    frame(-3, 5, 'h8000, 1'b0, 12);
    chk("unity_neg", {16'b0, last_l}, 32'hFFFD);
    chk("unity_pos", {16'b0, last_r}, 32'h0005);

    // Ramp to near 2.0 and saturate both rails.
    for (int i = 0; i < 9; i++) frame('h7FFF, -32768, 'hFFFF, 1'b0, 12);
    chk("sat_pos", {16'b0, last_l}, 32'h7FFF);
    chk("sat_neg", {16'b0, last_r}, 32'h8000);
    chk("gain_max", {16'b0, last_g}, 32'hFFFF);
`ifdef OUTPUT_FADER_CLIP_DETECT_EN
    chk("clip_l_set", {31'b0, clip_l}, 32'h1);
    chk("clip_r_set", {31'b0, clip_r}, 32'h1);
    @(negedge clk); clip_clear = 1'b1;
    @(negedge clk); clip_clear = 1'b0;
    chk("clip_l_clr", {31'b0, clip_l}, 32'h0);
    chk("clip_r_clr", {31'b0, clip_r}, 32'h0);
`endif

    // Ramp down with clamping onto a target that is not a step multiple away.
    for (int i = 0; i < 8; i++) frame('h1234, -'h1234, 'h8000, 1'b0, 12);
    chk("rampdown_gain", {16'b0, last_g}, 32'h8000);

    // Mute fades to zero in 8 frames.
    for (int i = 0; i < 8; i++) frame('h4000, -'h4000, 'h8000, 1'b1, 12);
    chk("mute_gain", {16'b0, last_g}, 32'h0000);
    frame('h4000, -'h4000, 'h8000, 1'b1, 12);
    chk("mute_out_l", {16'b0, last_l}, 32'h0000);
    chk("mute_out_r", {16'b0, last_r}, 32'h0000);

    // Unmute ramps back; a long lrclk high must give only one pulse.
    for (int i = 0; i < 3; i++) frame('h2000, 'h6000, 'h8000, 1'b0, 12);
    frame('h2000, 'h6000, 'h8000, 1'b0, 40);
    chk("unmute_gain", {16'b0, last_g}, 32'h4000);

    // Reset while the left product is being formed aborts the frame.
    @(negedge clk);
    in_l = 16'h3000; in_r = 16'h3000; target_gain = 16'h8000; mute = 1'b0;
    lrclk = 1'b1;
    repeat (4) @(negedge clk);
    rst = 1'b1; lrclk = 1'b0;
    @(negedge clk);
    chk("midrst_out_l", {16'b0, out_l}, 32'h0);
    chk("midrst_out_r", {16'b0, out_r}, 32'h0);
    chk("midrst_gain", {16'b0, cur_gain}, 32'h0);
    chk("midrst_valid", {31'b0, sample_valid}, 32'h0);
    rst = 1'b0;
    m_gain = 0;
    repeat (5) @(negedge clk);
    frame('h3000, -'h3000, 'h8000, 1'b0, 12);
    chk("post_rst_gain", {16'b0, last_g}, 32'h1000);

    repeat (5) @(negedge clk);
    chk("queue_empty", q.size(), 32'h0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
